// File: rtl/or_arb_pkg.sv
// Shared types and defaults for the OR-cell arbiter family.
package or_arb_pkg;

  // Operation phases of a shared-cell arbiter.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_SETTLE_CYC = 2;

  // Width of a counter that must be able to hold the value settle_cyc.
  function automatic int settle_width(input int settle_cyc);
    return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
  endfunction

  localparam int SETTLE_W = settle_width(DEF_SETTLE_CYC);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic             found;
  logic [IDX_W-1:0] k;

  // Walk the requesters starting at ptr and keep the first one that is asking.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/or_cell_arbiter.sv
// Shares one 2-input OR cell between N_REQ requesters with round-robin grant,
// holds operands for SETTLE_CYC cycles, samples out1 and golden-checks it.
module or_cell_arbiter
  import or_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] a_i,
  input  logic [N_REQ-1:0] b_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] done_o,
  output logic             res_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             cell_in1_o,
  output logic             cell_in2_o,
  input  logic             cell_out1_i
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = settle_width(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in1_q, in1_d;
  logic             in2_q, in2_d;
  logic             res_q, res_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state and datapath: grant in IDLE, count in SETTLE, report and rotate in DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SETTLE;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          in1_d   = a_i[pick_idx];
          in2_d   = b_i[pick_idx];
          cnt_d   = '0;
        end else begin
          gnt_d = '0;
          in1_d = 1'b0;
          in2_d = 1'b0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = cell_out1_i;
          done_d  = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = err_q | (res_q != (in1_q | in2_q));
        ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        gnt_d   = '0;
        in1_d   = 1'b0;
        in2_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        in1_d   = 1'b0;
        in2_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign res_o      = res_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);
  assign cell_in1_o = in1_q;
  assign cell_in2_o = in2_q;

endmodule

// File: tb/tb_or_cell_arbiter.sv
// Self-checking bench for or_cell_arbiter with a behavioural OR cell and stuck-at faults.
module tb_or_cell_arbiter;
  import or_arb_pkg::*;

  localparam int N  = 4;
  localparam int SC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_i, a_i, b_i;
  logic [N-1:0] gnt_o, done_o;
  logic         res_o, busy_o, err_o, cell_in1, cell_in2, cell_out1;
  logic         stuck0 = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_gnt;
    logic         exp_in1;
    logic         exp_in2;
    logic         exp_res;
  } vec_t;

  vec_t vecs[9];

  // Behavioural cell with an optional stuck-at-0 on out1.
  assign cell_out1 = stuck0 ? 1'b0 : (cell_in1 | cell_in2);

  or_cell_arbiter #(.N_REQ(N), .SETTLE_CYC(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .res_o       (res_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .cell_in1_o  (cell_in1),
    .cell_in2_o  (cell_in2),
    .cell_out1_i (cell_out1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b);
    req_i = r;
    a_i   = a;
    b_i   = b;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus('0, '0, '0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: operation phase counter plus round-robin pointer.
  int           m_phase, m_w, m_ptr;
  logic         m_a, m_b, m_res, m_err;
  logic [N-1:0] eg, ed;

  task automatic modelReset();
    m_phase = 0; m_w = 0; m_ptr = 0;
    m_a = 0; m_b = 0; m_res = 0; m_err = 0;
  endtask

  task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] a, input logic [N-1:0] b);
    bit found;
    found = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!found && r[k]) begin
          found = 1; m_w = k; m_a = a[k]; m_b = b[k]; m_phase = 1;
        end
      end
    end else if (m_phase == SC + 1) begin
      m_err   = m_err | (m_res != (m_a | m_b));
      m_ptr   = (m_w + 1) % N;
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == SC + 1) m_res = m_a | m_b;
    end
  endtask

  initial begin
    int done_cnt[N];
    int ops;

    vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{4'b0101, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{4'b0110, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    applyStimulus('0, '0, '0);
    #1;
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_res", res_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_in1", cell_in1, 0);
    checkOutput("rst_in2", cell_in2, 0);
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].req, vecs[v].a, vecs[v].b);
      tick();
      checkOutput("vec_gnt_c1", gnt_o, vecs[v].exp_gnt);
      checkOutput("vec_in1_c1", cell_in1, vecs[v].exp_in1);
      checkOutput("vec_in2_c1", cell_in2, vecs[v].exp_in2);
      checkOutput("vec_busy_c1", busy_o, 1);
      applyStimulus(vecs[v].req, ~vecs[v].a, ~vecs[v].b);
      tick();
      checkOutput("vec_gnt_c2", gnt_o, vecs[v].exp_gnt);
      checkOutput("vec_in1_frozen", cell_in1, vecs[v].exp_in1);
      checkOutput("vec_done_c2", done_o, 0);
      tick();
      checkOutput("vec_done_c3", done_o, vecs[v].exp_gnt);
      checkOutput("vec_res_c3", res_o, vecs[v].exp_res);
      checkOutput("vec_gnt_c3", gnt_o, vecs[v].exp_gnt);
      req_i = '0;
      tick();
      checkOutput("vec_done_c4", done_o, 0);
      checkOutput("vec_busy_c4", busy_o, 0);
      checkOutput("vec_in1_c4", cell_in1, 0);
      checkOutput("vec_err_c4", err_o, 0);
    end

    $display("[TB] all requesters active for 20 ops");
    resetDut();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    ops = 0;
    applyStimulus('1, 4'($urandom), 4'($urandom));
    for (int c = 1; c <= 20 * (SC + 2); c++) begin
      tick();
      if (done_o != '0) begin
        checkOutput("rr_done_order", done_o, 32'(1) << (ops % N));
        for (int i = 0; i < N; i++) if (done_o[i]) done_cnt[i]++;
        ops++;
      end
    end
    req_i = '0;
    checkOutput("rr_ops", ops, 20);
    for (int i = 0; i < N; i++) checkOutput("rr_per_req", done_cnt[i], 5);

    $display("[TB] stuck-at-0 cell");
    stuck0 = 1'b1;
    applyStimulus(4'b0010, 4'b0010, 4'b0010);
    tick();
    checkOutput("flt_gnt", gnt_o, 4'b0010);
    tick();
    stuck0 = 1'b1;
    tick();
    checkOutput("flt_done", done_o, 4'b0010);
    checkOutput("flt_res", res_o, 0);
    tick();
    checkOutput("flt_err", err_o, 1);
    stuck0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      checkOutput("flt_good_done", done_o, 4'b0010);
      checkOutput("flt_good_res", res_o, 1);
      tick();
      checkOutput("flt_err_sticky", err_o, 1);
    end
    req_i = '0;

    $display("[TB] reset mid-operation");
    resetDut();
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    tick();
    tick();
    checkOutput("ar_busy_pre", busy_o, 1);
    #2;
    rst_n = 1'b0;
    req_i = '0;
    #1;
    checkOutput("ar_gnt", gnt_o, 0);
    checkOutput("ar_done", done_o, 0);
    checkOutput("ar_busy", busy_o, 0);
    checkOutput("ar_in1", cell_in1, 0);
    checkOutput("ar_res", res_o, 0);
    tick();
    checkOutput("ar_done_held", done_o, 0);
    rst_n = 1'b1;
    applyStimulus(4'b1000, 4'b1000, 4'b1000);
    tick();
    checkOutput("ar_regrant", gnt_o, 4'b1000);
    tick();
    tick();
    checkOutput("ar_done_after", done_o, 4'b1000);
    req_i = '0;
    tick();

    $display("[TB] requester drops mid-operation");
    applyStimulus(4'b1001, 4'b0001, 4'b0000);
    tick();
    checkOutput("drop_gnt0", gnt_o, 4'b0001);
    req_i = 4'b1000;
    tick();
    tick();
    checkOutput("drop_done0", done_o, 4'b0001);
    tick();
    checkOutput("drop_idle", busy_o, 0);
    tick();
    checkOutput("drop_gnt3", gnt_o, 4'b1000);
    tick();
    tick();
    checkOutput("drop_done3", done_o, 4'b1000);
    req_i = '0;
    tick();

    $display("[TB] randomized against reference model");
    resetDut();
    modelReset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] r, a, b;
      eg = '0;
      ed = '0;
      if (m_phase != 0) eg[m_w] = 1'b1;
      if (m_phase == SC + 1) ed[m_w] = 1'b1;
      checkOutput("rnd_gnt", gnt_o, eg);
      checkOutput("rnd_done", done_o, ed);
      checkOutput("rnd_busy", busy_o, m_phase != 0);
      checkOutput("rnd_in1", cell_in1, (m_phase != 0) ? m_a : 1'b0);
      checkOutput("rnd_in2", cell_in2, (m_phase != 0) ? m_b : 1'b0);
      checkOutput("rnd_res", res_o, m_res);
      checkOutput("rnd_err", err_o, m_err);
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      applyStimulus(r, a, b);
      modelStep(r, a, b);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
